// File: rtl/g_buf_pkg.sv
// Shared constants and elaboration helpers for the filtered input buffer family.
package g_buf_pkg;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 64;
    localparam int unsigned SYNC_MIN  = 2;
    localparam int unsigned SYNC_MAX  = 4;
    localparam int unsigned FILT_MIN  = 1;
    localparam int unsigned FILT_MAX  = 255;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Counter must hold 0..FILT_CYC; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned filt_cyc);
        int unsigned w;
        w = clog2(filt_cyc + 1);
        return (w == 0) ? 1 : w;
    endfunction

    localparam int unsigned CNT_W_MAX = cnt_width(FILT_MAX);

    function automatic bit in_range(input int unsigned v, input int unsigned lo,
                                    input int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/g_bufb_filt_ch.sv
// One channel: synchroniser chain, polarity correction, consecutive-sample
// deglitch counter and registered level/edge outputs.
module g_bufb_filt_ch
    import g_buf_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CYC    = 4,
    parameter logic        INV         = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic an,
    input  logic en,
    output logic y,
    output logic rise,
    output logic fall
);

    localparam int unsigned     CW       = cnt_width(FILT_CYC);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILT_CYC - 1);

    if (!in_range(SYNC_STAGES, SYNC_MIN, SYNC_MAX)) begin : g_bad_sync
        $fatal(1, "g_bufb_filt_ch: SYNC_STAGES out of range");
    end
    if (!in_range(FILT_CYC, FILT_MIN, FILT_MAX)) begin : g_bad_filt
        $fatal(1, "g_bufb_filt_ch: FILT_CYC out of range");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   y_q, y_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s_c;

    // Sync chain runs every cycle regardless of EN.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], an};
        s_c    = sync_q[SYNC_STAGES-1] ^ INV;
    end

    // Any sample matching Y restarts the count; the FILT_CYC-th mismatch commits.
    always_comb begin
        cnt_d  = cnt_q;
        y_d    = y_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (en) begin
            if (s_c == y_q) begin
                cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
                y_d    = s_c;
                cnt_d  = '0;
                rise_d = s_c;
                fall_d = ~s_c;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{INV}};
            cnt_q  <= '0;
            y_q    <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            y_q    <= y_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign y    = y_q;
    assign rise = rise_q;
    assign fall = fall_q;

    a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(rise_q && fall_q));

endmodule

// File: rtl/g_bufb_filt.sv
// WIDTH-channel synchronised, deglitched, polarity-corrected input buffer with
// per-channel rise/fall strobes and a shared filter enable.
module g_bufb_filt
    import g_buf_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      FILT_CYC    = 4,
    parameter logic [WIDTH-1:0] INV_MASK    = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [WIDTH-1:0] AN,
    input  logic             EN,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL
);

    if (!in_range(WIDTH, WIDTH_MIN, WIDTH_MAX)) begin : g_bad_width
        $fatal(1, "g_bufb_filt: WIDTH out of range");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        g_bufb_filt_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_CYC    (FILT_CYC),
            .INV         (INV_MASK[i])
        ) u_ch (
            .clk   (CLK),
            .rst_n (RSTN),
            .an    (AN[i]),
            .en    (EN),
            .y     (Y[i]),
            .rise  (RISE[i]),
            .fall  (FALL[i])
        );
    end

endmodule
